// File: rtl/data_capture_pkg.sv
// Shared defaults and types for the data capture FIFO slice.
// Provides width/depth defaults, overflow counter width and the data byte type.
package data_capture_pkg;

    localparam int DC_WIDTH_DEF = 8;
    localparam int DC_DEPTH_DEF = 4;
    localparam int OVF_CNT_W    = 16;

    typedef logic [DC_WIDTH_DEF-1:0] dc_data_t;

endpackage

// File: rtl/data_capture_mem.sv
// Storage array for the data capture FIFO: synchronous write,
// asynchronous read, synchronous clear of every entry on rst.
// Ports: clk, rst, we, waddr, wdata (write side); raddr, rdata (read side).
module data_capture_mem
    import data_capture_pkg::*;
#(
    parameter int WIDTH = DC_WIDTH_DEF,
    parameter int DEPTH = DC_DEPTH_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [WIDTH-1:0]         rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/data_capture_fifo.sv
// Show-ahead valid/ready FIFO capturing the combinational stage result byte.
// Ports: clk, rst (sync, active-high); wr_data/wr_valid/wr_ready write side;
// rd_data/rd_valid/rd_ready read side; level = stored entries;
// ovf_cnt = saturating rejected-write count, only with DATA_CAPTURE_OVF_CNT_EN.
module data_capture_fifo
    import data_capture_pkg::*;
#(
    parameter int WIDTH = DC_WIDTH_DEF,
    parameter int DEPTH = DC_DEPTH_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [WIDTH-1:0]       wr_data,
    input  logic                   wr_valid,
    output logic                   wr_ready,
    output logic [WIDTH-1:0]       rd_data,
    output logic                   rd_valid,
    input  logic                   rd_ready,
    output logic [$clog2(DEPTH):0] level
`ifdef DATA_CAPTURE_OVF_CNT_EN
    ,
    output logic [OVF_CNT_W-1:0]   ovf_cnt
`endif
);

    localparam int AW = $clog2(DEPTH);

    // Pointers carry one extra wrap bit to tell FULL from EMPTY.
    logic [AW:0] wp;
    logic [AW:0] rp;
    logic        full;
    logic        empty;
    logic        push;
    logic        pop;

    assign empty = (wp == rp);
    assign full  = (wp[AW-1:0] == rp[AW-1:0])
                && (wp[AW] != rp[AW]);

    assign wr_ready = !full && !rst;
    assign rd_valid = !empty;
    assign level    = wp - rp;

    assign push = wr_valid && wr_ready;
    assign pop  = rd_valid && rd_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            wp <= '0;
            rp <= '0;
        end else begin
            if (push) wp <= wp + 1'b1;
            if (pop)  rp <= rp + 1'b1;
        end
    end

    data_capture_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk   (clk),
        .rst   (rst),
        .we    (push),
        .waddr (wp[AW-1:0]),
        .wdata (wr_data),
        .raddr (rp[AW-1:0]),
        .rdata (rd_data)
    );

`ifdef DATA_CAPTURE_OVF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_cnt <= '0;
        end else if (wr_valid && full && (ovf_cnt != '1)) begin
            ovf_cnt <= ovf_cnt + 1'b1;
        end
    end
`endif

endmodule
